// File: rtl/load_store_unit_if.sv
// load_store_unit_if: bundles the request/response handshake and the data-memory bus of the LSU.
//   req_*      : execute-stage request (valid/ready handshake, store flag, funct3, byte address, store data)
//   resp_*     : one-cycle response pulse with extended load data and error flag
//   mem_*      : synchronous data-memory port (enable, word address, write data, store enable, read data)
//   modport slave  : the load/store unit itself
//   modport master : its environment (execute stage plus data memory)
interface load_store_unit_if #(
    parameter int MEM_ADDR_W = 11
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [2:0]            req_funct3;
    logic [31:0]           req_addr;
    logic [31:0]           req_wdata;
    logic                  resp_valid;
    logic [31:0]           resp_rdata;
    logic                  resp_error;
    logic                  mem_enable;
    logic [MEM_ADDR_W-1:0] mem_addr;
    logic [31:0]           mem_wdata;
    logic                  mem_store_enable;
    logic [31:0]           mem_rdata;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_error,
        output mem_enable, mem_addr, mem_wdata, mem_store_enable
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_error,
        input  mem_enable, mem_addr, mem_wdata, mem_store_enable
    );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit: RV32I load/store initiator for a word-wide synchronous data memory.
//   clk   : rising-edge clock
//   reset : synchronous active-high reset; also gates the memory enables off combinationally
//   bus   : load_store_unit_if.slave carrying the request/response handshake and the memory port
// Sub-word stores are done as read-modify-write since the memory only writes whole words.
module load_store_unit #(
    parameter int MEM_ADDR_W = 11
) (
    input logic              clk,
    input logic              reset,
    load_store_unit_if.slave bus
);
    localparam int AW = MEM_ADDR_W + 2;

    typedef enum logic [2:0] {IDLE, ISSUE, DATA, WRITE, RESP} state_t;

    state_t          state, state_nx;
    logic            we_q;
    logic [2:0]      f3_q;
    logic [AW-1:0]   addr_q;
    logic [31:0]     wdata_q;
    logic [31:0]     rdata_q;
    logic            err_q;
    logic            accept, bad, en, st, is_sw;
    logic [7:0]      byte_v;
    logic [15:0]     half_v;
    logic [31:0]     load_v, mask, fill, merged;

    assign accept = bus.req_valid && state == IDLE;
    assign is_sw  = we_q && f3_q[1];

    // Illegal funct3 or misalignment is decided on the raw request, before capture.
    always_comb begin
        bad = bus.req_we ? bus.req_funct3 > 3'd2
                         : !(bus.req_funct3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        bad = bad || (bus.req_funct3[1:0] == 2'd1 && bus.req_addr[0])
                  || (bus.req_funct3[1:0] == 2'd2 && bus.req_addr[1:0] != 2'b00);
    end

    // Lane extraction for loads and lane merge for sub-word stores; funct3[2] selects zero-extension.
    always_comb begin
        byte_v = 8'(bus.mem_rdata >> {addr_q[1:0], 3'b000});
        half_v = addr_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
        load_v = f3_q[1] ? bus.mem_rdata
               : f3_q[0] ? {{16{~f3_q[2] & half_v[15]}}, half_v}
               : {{24{~f3_q[2] & byte_v[7]}}, byte_v};
        mask   = f3_q[0] ? 32'h0000_FFFF << {addr_q[1], 4'b0000}
                         : 32'h0000_00FF << {addr_q[1:0], 3'b000};
        fill   = f3_q[0] ? {2{wdata_q[15:0]}} : {4{wdata_q[7:0]}};
        merged = (bus.mem_rdata & ~mask) | (fill & mask);
    end

    always_comb begin
        state_nx = state;
        en       = 1'b0;
        st       = 1'b0;
        case (state)
            IDLE:    state_nx = accept ? (bad ? RESP : ISSUE) : IDLE;
            ISSUE: begin
                en       = 1'b1;
                st       = is_sw;
                state_nx = is_sw ? RESP : DATA;
            end
            DATA:    state_nx = we_q ? WRITE : RESP;
            WRITE: begin
                en       = 1'b1;
                st       = 1'b1;
                state_nx = RESP;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Reset masks the strobes so a write in flight is never committed.
    assign bus.mem_enable       = en && !reset;
    assign bus.mem_store_enable = st && !reset;
    assign bus.mem_addr         = (en && !reset) ? addr_q[AW-1:2] : '0;
    assign bus.mem_wdata        = (st && !reset) ? wdata_q : '0;
    assign bus.req_ready        = state == IDLE;
    assign bus.resp_valid       = state == RESP;
    assign bus.resp_rdata       = rdata_q;
    assign bus.resp_error       = err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            we_q    <= 1'b0;
            f3_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                we_q    <= bus.req_we;
                f3_q    <= bus.req_funct3;
                addr_q  <= bus.req_addr[AW-1:0];
                wdata_q <= bus.req_wdata;
                if (bad) begin
                    err_q   <= 1'b1;
                    rdata_q <= '0;
                end
            end
            if ((state == ISSUE && is_sw) || state == WRITE) begin
                err_q   <= 1'b0;
                rdata_q <= '0;
            end
            // The merged word reuses the store-data register for the WRITE cycle.
            if (state == DATA && we_q) wdata_q <= merged;
            if (state == DATA && !we_q) begin
                rdata_q <= load_v;
                err_q   <= 1'b0;
            end
        end
    end
endmodule
